// File: rtl/axi4_lite_read_arbiter.sv
// Two-port (fetch = port 0, load = port 1) arbiter in front of a single AXI4-Lite read master.
// Optional macro RD_ARB_FIXED_PRIO_EN: port 1 always wins ties; default is round-robin.
module axi4_lite_read_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req_i,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    output logic                  p0_ack_o,
    output logic                  p0_rvalid_o,
    output logic [DATA_WIDTH-1:0] p0_rdata_o,
    input  logic                  p1_req_i,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    output logic                  p1_ack_o,
    output logic                  p1_rvalid_o,
    output logic [DATA_WIDTH-1:0] p1_rdata_o,
    output logic                  read_start_o,
    output logic [ADDR_WIDTH-1:0] read_addr_o,
    input  logic [DATA_WIDTH-1:0] read_data_i,
    input  logic                  read_busy_i,
    output logic                  arb_busy_o,
    output logic                  last_grant_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    win_q, win_d;
    logic                    last_grant_q, last_grant_d;
    logic                    read_start_q, read_start_d;
    logic [ADDR_WIDTH-1:0]   read_addr_q, read_addr_d;
    logic                    arb_busy_q, arb_busy_d;
    logic                    rvalid0_q, rvalid0_d;
    logic                    rvalid1_q, rvalid1_d;
    logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;
    logic                    pick1;
    logic                    ack0_c, ack1_c;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            win_q        <= 1'b0;
            last_grant_q <= 1'b1;
            read_start_q <= 1'b0;
            read_addr_q  <= '0;
            arb_busy_q   <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            last_grant_q <= last_grant_d;
            read_start_q <= read_start_d;
            read_addr_q  <= read_addr_d;
            arb_busy_q   <= arb_busy_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Winner selection, next state and next outputs
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        last_grant_d = last_grant_q;
        read_start_d = 1'b0;
        read_addr_d  = '0;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        ack0_c       = 1'b0;
        ack1_c       = 1'b0;

        pick1 = p1_req_i;
        if (p0_req_i && p1_req_i) begin
`ifdef RD_ARB_FIXED_PRIO_EN
            pick1 = 1'b1;
`else
            pick1 = ~last_grant_q;
`endif
        end

        case (state_q)
            IDLE: begin
                if (p0_req_i || p1_req_i) begin
                    ack0_c       = ~pick1;
                    ack1_c       = pick1;
                    win_d        = pick1;
                    last_grant_d = pick1;
                    read_start_d = 1'b1;
                    read_addr_d  = pick1 ? p1_addr_i : p0_addr_i;
                    state_d      = START;
                end
            end
            START: begin
                state_d = BUSY;
            end
            BUSY: begin
                // Master holds read_busy high from the cycle after read_start until data is ready
                if (!read_busy_i) begin
                    if (win_q) begin
                        rdata1_d  = read_data_i;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = read_data_i;
                        rvalid0_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        arb_busy_d = (state_d != IDLE);
    end

    assign p0_ack_o     = ack0_c;
    assign p1_ack_o     = ack1_c;
    assign p0_rvalid_o  = rvalid0_q;
    assign p1_rvalid_o  = rvalid1_q;
    assign p0_rdata_o   = rdata0_q;
    assign p1_rdata_o   = rdata1_q;
    assign read_start_o = read_start_q;
    assign read_addr_o  = read_addr_q;
    assign arb_busy_o   = arb_busy_q;
    assign last_grant_o = last_grant_q;

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// Scoreboard bench for axi4_lite_read_arbiter with a behavioural read-master model.
`timescale 1ns/1ps
module tb_axi4_lite_read_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req, p1_req;
    logic [AW-1:0] p0_addr, p1_addr;
    logic          p0_ack, p1_ack, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          read_start;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] read_data;
    logic          read_busy;
    logic          arb_busy, last_grant;

    axi4_lite_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_i(p0_req), .p0_addr_i(p0_addr), .p0_ack_o(p0_ack),
        .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
        .p1_req_i(p1_req), .p1_addr_i(p1_addr), .p1_ack_o(p1_ack),
        .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
        .read_start_o(read_start), .read_addr_o(read_addr),
        .read_data_i(read_data), .read_busy_i(read_busy),
        .arb_busy_o(arb_busy), .last_grant_o(last_grant)
    );

    always #5 clk = ~clk;

    typedef struct { bit port; logic [DW-1:0] data; int due; } exp_t;
    typedef struct { int cnt; logic [DW-1:0] data; } mst_t;

    exp_t sb[$];
    mst_t mq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    // Stimulus knobs for the master latency and data of the next grant
    bit            rnd_waits = 1'b0;
    int            f_ar = 0, f_r = 0;
    bit            f_data_en = 1'b0;
    logic [DW-1:0] f_data = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Read master: busy for 2 + ARREADY wait + RVALID wait cycles after read_start, data on busy fall
    int            m_cnt = 0;
    logic [DW-1:0] m_data;
    mst_t          cur;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_busy <= 1'b0;
            read_data <= '0;
            m_cnt = 0;
            mq.delete();
        end else if (read_start === 1'b1) begin
            if (mq.size() == 0) begin
                chk("unexpected_read_start", 64'(1), 64'(0));
            end else begin
                cur = mq.pop_front();
                m_cnt = cur.cnt;
                m_data = cur.data;
                read_busy <= 1'b1;
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                read_busy <= 1'b0;
                read_data <= m_data;
            end
        end
    end

    // Reference model: grant decisions and expected transaction timing
    bit            m_free = 1'b1;
    int            m_free_at = -1;
    int            m_start_cyc = -1;
    bit            m_last = 1'b1;
    logic [AW-1:0] m_addr = '0;
    bit            m_grant, m_w;
    int            ar, r;
    logic [DW-1:0] d;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_ctrl", 64'({p0_ack, p1_ack, p0_rvalid, p1_rvalid, read_start, arb_busy, last_grant}),
                64'(7'b0000001));
            chk("reset_addr", 64'(read_addr), 64'(0));
            chk("reset_rdata", 64'({p0_rdata, p1_rdata}), 64'(0));
            m_free = 1'b1; m_free_at = -1; m_start_cyc = -1; m_last = 1'b1;
        end else begin
            if (cyc == m_free_at) m_free = 1'b1;
            m_grant = 1'b0;
            m_w = 1'b0;
            if (m_free && (p0_req || p1_req)) begin
                m_grant = 1'b1;
                if (p0_req && p1_req) begin
`ifdef RD_ARB_FIXED_PRIO_EN
                    m_w = 1'b1;
`else
                    m_w = !m_last;
`endif
                end else begin
                    m_w = p1_req;
                end
            end
            chk("ack", 64'({p1_ack, p0_ack}), 64'(m_grant ? (m_w ? 2'b10 : 2'b01) : 2'b00));
            chk("arb_busy", 64'(arb_busy), 64'(!m_free));
            chk("last_grant", 64'(last_grant), 64'(m_last));
            chk("read_start", 64'(read_start), 64'(cyc == m_start_cyc));
            chk("read_addr", 64'(read_addr), 64'((cyc == m_start_cyc) ? m_addr : '0));
            if (m_grant) begin
                m_free = 1'b0;
                m_last = m_w;
                m_start_cyc = cyc + 1;
                m_addr = m_w ? p1_addr : p0_addr;
                ar = rnd_waits ? int'($urandom_range(0, 3)) : f_ar;
                r  = rnd_waits ? int'($urandom_range(0, 3)) : f_r;
                d  = f_data_en ? f_data : DW'($urandom);
                mq.push_back('{cnt: 2 + ar + r, data: d});
                sb.push_back('{port: m_w, data: d, due: cyc + 5 + ar + r});
                m_free_at = cyc + 5 + ar + r;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT returns data
    logic [DW-1:0] e_rd0 = '0, e_rd1 = '0;
    exp_t          e;
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            e_rd0 = '0;
            e_rd1 = '0;
        end else begin
            if (p0_rvalid || p1_rvalid) begin
                if (sb.size() == 0) begin
                    chk("rvalid_unexpected", 64'({p1_rvalid, p0_rvalid}), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("rvalid_port", 64'({p1_rvalid, p0_rvalid}), 64'(e.port ? 2'b10 : 2'b01));
                    chk("rvalid_cycle", 64'(cyc), 64'(e.due));
                    if (e.port) e_rd1 = e.data;
                    else        e_rd0 = e.data;
                end
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                chk("rvalid_missing", 64'(0), 64'(1));
                void'(sb.pop_front());
            end
            chk("p0_rdata", 64'(p0_rdata), 64'(e_rd0));
            chk("p1_rdata", 64'(p1_rdata), 64'(e_rd1));
        end
    end

    task automatic set_req(input bit p, input bit v, input logic [AW-1:0] a);
        if (p) begin p1_req = v; p1_addr = a; end
        else   begin p0_req = v; p0_addr = a; end
    endtask

    // Raise a request, hold until ack (or drop after drop_after unacked cycles), then release
    task automatic req_once(input bit p, input logic [AW-1:0] a, input int drop_after);
        bit acked = 1'b0;
        set_req(p, 1'b1, a);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if ((p ? p1_ack : p0_ack) === 1'b1) begin acked = 1'b1; break; end
            if (drop_after > 0 && k + 1 >= drop_after) break;
        end
        if (!acked && drop_after == 0) chk("ack_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        set_req(p, 1'b0, '0);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (m_free && sb.size() == 0) begin done = 1'b1; break; end
        end
        if (!done) chk("idle_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        p0_req = 1'b0; p1_req = 1'b0; p0_addr = '0; p1_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single p0 read, zero-wait slave, known data
        f_data_en = 1'b1; f_data = 32'hCAFE_F00D;
        req_once(1'b0, 32'h0000_0100, 0);
        f_data_en = 1'b0;
        wait_idle();

        // Simultaneous requests, then both held continuously for six grants
        fork
            req_once(1'b0, 32'h10, 0);
            req_once(1'b1, 32'h20, 0);
        join
        wait_idle();
        fork
            for (int i = 0; i < 3; i++) req_once(1'b0, AW'(32'h1000 + i * 4), 0);
            for (int i = 0; i < 3; i++) req_once(1'b1, AW'(32'h2000 + i * 4), 0);
        join
        wait_idle();

        // Slow slave: ARREADY 3 waits, RVALID 2 waits
        f_ar = 3; f_r = 2;
        req_once(1'b1, 32'h0000_0300, 0);
        wait_idle();
        f_ar = 0; f_r = 0;

        // Reset during BUSY aborts the read; next p1 read completes normally
        req_once(1'b0, 32'h0000_0200, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_ctrl", 64'({p0_ack, p1_ack, p0_rvalid, p1_rvalid, read_start, arb_busy, last_grant}),
            64'(7'b0000001));
        chk("async_reset_rdata", 64'({p0_rdata, p1_rdata}), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req_once(1'b1, 32'h0000_0044, 0);
        wait_idle();

        // p1 request raised and dropped while p0 is in flight
        fork
            req_once(1'b0, 32'h0000_0300, 0);
            begin
                repeat (3) @(posedge clk);
                #1 set_req(1'b1, 1'b1, 32'h0000_0600);
                repeat (2) @(posedge clk);
                #1 set_req(1'b1, 1'b0, '0);
            end
        join
        wait_idle();

        // Randomized traffic with random slave latency and occasional abandoned requests
        rnd_waits = 1'b1;
        fork
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1 req_once(1'b0, AW'($urandom) & ~AW'(3),
                            ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
            end
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1 req_once(1'b1, AW'($urandom) & ~AW'(3),
                            ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
            end
        join
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
